// File: rtl/targetc_axil_regbank_if.sv
// AXI4-Lite bus between the PS/VIP master and the TARGETC register bank.
// Clock and reset stay outside; the bank samples everything on ACLK.
interface targetc_axil_regbank_if #(
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/targetc_axil_regbank.sv
// AXI4-Lite control/status register bank; write commits on the edge AW and W are both held, read data one edge after AR.
// One write and one read outstanding; AW/W/AR stall only while the matching response is unacknowledged.
module targetc_axil_regbank #(
    parameter int          ADDR_WIDTH = 7,
    parameter int          NUM_CTRL   = 4,
    parameter int          NUM_STAT   = 4,
    parameter logic [31:0] CTRL_RST   = 32'h0
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    targetc_axil_regbank_if.slave    S_AXI,
    output logic [32*NUM_CTRL-1:0]   ctrl_regs,
    output logic [NUM_CTRL-1:0]      ctrl_wr_strobe,
    input  logic [32*NUM_STAT-1:0]   stat_in
);
    localparam int              IDX_W    = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0]  CTRL_END = NUM_CTRL[IDX_W:0];
    localparam logic [IDX_W:0]  MAP_END  = CTRL_END + NUM_STAT[IDX_W:0];
    localparam logic [1:0]      OKAY     = 2'b00;
    localparam logic [1:0]      SLVERR   = 2'b10;

    logic             run;
    logic             aw_got, w_got;
    logic [IDX_W-1:0] aw_idx;
    logic [31:0]      w_dat;
    logic [3:0]       w_strb;
    logic             bvalid, rvalid;
    logic [1:0]       bresp, rresp;
    logic [31:0]      rdata;

    logic             awready, wready, arready;
    logic             aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_dat, rd_word;
    logic [3:0]       wr_strb;
    logic             wr_err, rd_err;
    logic [NUM_CTRL-1:0] wr_hit;
    logic             unused_bits;

    // run holds READY low from reset assertion until the first edge after release
    assign awready = run & ~aw_got & ~bvalid;
    assign wready  = run & ~w_got & ~bvalid;
    assign arready = run & ~rvalid;

    assign aw_hs  = S_AXI.awvalid & awready;
    assign w_hs   = S_AXI.wvalid & wready;
    assign ar_hs  = S_AXI.arvalid & arready;
    assign commit = (aw_got | aw_hs) & (w_got | w_hs);

    assign S_AXI.awready = awready;
    assign S_AXI.wready  = wready;
    assign S_AXI.bvalid  = bvalid;
    assign S_AXI.bresp   = bresp;
    assign S_AXI.arready = arready;
    assign S_AXI.rvalid  = rvalid;
    assign S_AXI.rresp   = rresp;
    assign S_AXI.rdata   = rdata;

    assign unused_bits = ^{S_AXI.awprot, S_AXI.arprot, S_AXI.awaddr[1:0], S_AXI.araddr[1:0]};

    always_comb begin
        wr_idx  = aw_got ? aw_idx : S_AXI.awaddr[ADDR_WIDTH-1:2];
        wr_dat  = w_got ? w_dat : S_AXI.wdata;
        wr_strb = w_got ? w_strb : S_AXI.wstrb;
        rd_idx  = S_AXI.araddr[ADDR_WIDTH-1:2];
        wr_err  = ({1'b0, wr_idx} >= MAP_END);
        rd_err  = ({1'b0, rd_idx} >= MAP_END);
        wr_hit  = '0;
        rd_word = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if ({1'b0, wr_idx} == k[IDX_W:0]) wr_hit[k] = 1'b1;
            if ({1'b0, rd_idx} == k[IDX_W:0]) rd_word = ctrl_regs[32*k +: 32];
        end
        for (int k = 0; k < NUM_STAT; k++) begin
            if ({1'b0, rd_idx} == CTRL_END + k[IDX_W:0]) rd_word = stat_in[32*k +: 32];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run            <= 1'b0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
            aw_idx         <= '0;
            w_dat          <= '0;
            w_strb         <= '0;
            bvalid         <= 1'b0;
            bresp          <= OKAY;
            ctrl_wr_strobe <= '0;
            ctrl_regs      <= {NUM_CTRL{CTRL_RST}};
        end else begin
            run            <= 1'b1;
            ctrl_wr_strobe <= '0;
            if (aw_hs) aw_idx <= S_AXI.awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                w_dat  <= S_AXI.wdata;
                w_strb <= S_AXI.wstrb;
            end
            if (commit) begin
                aw_got         <= 1'b0;
                w_got          <= 1'b0;
                bvalid         <= 1'b1;
                bresp          <= wr_err ? SLVERR : OKAY;
                ctrl_wr_strobe <= wr_hit;
                for (int k = 0; k < NUM_CTRL; k++) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_hit[k] && wr_strb[b])
                            ctrl_regs[32*k+8*b +: 8] <= wr_dat[8*b +: 8];
                    end
                end
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
                if (bvalid && S_AXI.bready) bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured from the pre-edge register state, so a same-edge write is not visible
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid <= 1'b0;
            rresp  <= OKAY;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rresp  <= rd_err ? SLVERR : OKAY;
            rdata  <= rd_word;
        end else if (rvalid && S_AXI.rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule
